// File: rtl/shift_mult_pkg.sv
// -----------------------------------------------------------------------------
// shift_mult_pkg
// Shared definitions for the 4x4 shift multiplier and its downstream
// product accumulator.
//   PW_DEF / ACC_W_DEF / LEN_DEF : default product width, accumulator width
//                                  and products per result.
//   acc_state_t                  : accumulator control states.
//   cnt_width()                  : width of a counter that must reach len.
// -----------------------------------------------------------------------------
package shift_mult_pkg;

  localparam int PW_DEF    = 8;
  localparam int ACC_W_DEF = 12;
  localparam int LEN_DEF   = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  // A term counter has to represent 0..len inclusive.
  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// -----------------------------------------------------------------------------
// product_accumulator_if
// Product input and result output handshakes of product_accumulator.
//   in_valid / in_ready / in_product           : product stream (valid/ready).
//   out_valid / out_ready / out_sum / out_overflow : result stream (valid/ready).
//   term_cnt                                   : products taken toward the
//                                                current result.
// Modports: slave = the accumulator, master = producer/sink side.
// -----------------------------------------------------------------------------
interface product_accumulator_if #(
  parameter int PW    = shift_mult_pkg::PW_DEF,
  parameter int ACC_W = shift_mult_pkg::ACC_W_DEF,
  parameter int LEN   = shift_mult_pkg::LEN_DEF
) ();

  localparam int CNT_W = shift_mult_pkg::cnt_width(LEN);

  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    in_product;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_overflow;
  logic [CNT_W-1:0] term_cnt;

  modport slave (
    input  in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_overflow, term_cnt
  );

  modport master (
    output in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_overflow, term_cnt
  );

endinterface

// File: rtl/product_accumulator_add.sv
// -----------------------------------------------------------------------------
// acc_sat_add
// Combinational ACC_W-bit unsigned adder with carry-out.
//   a, b  : addends (ACC_W bits).
//   sum   : ACC_W-bit result; wraps modulo 2^ACC_W by default.
//   carry : carry-out of the ACC_W+1-bit addition.
// Build option: PRODUCT_ACC_SATURATE_EN clamps sum to all ones whenever the
// addition carries out.
// -----------------------------------------------------------------------------
module acc_sat_add #(
  parameter int ACC_W = shift_mult_pkg::ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b};
  assign carry  = w_full[ACC_W];

`ifdef PRODUCT_ACC_SATURATE_EN
  // Once clamped, any further nonzero addend carries again and re-clamps,
  // so the accumulator stays pinned at the maximum for the rest of the result.
  assign sum = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
  assign sum = w_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
// Sums LEN consecutive unsigned products into one result and holds it on a
// valid/ready output until the sink takes it.
//   clk  : rising-edge clock.
//   rst  : asynchronous active-high reset.
//   clr  : synchronous abort of the partial sum and of any held result.
//   bus  : product_accumulator_if.slave (product in, result out, term_cnt).
// Build option: PRODUCT_ACC_SATURATE_EN (saturating adds, see acc_sat_add).
// -----------------------------------------------------------------------------
module product_accumulator
  import shift_mult_pkg::*;
#(
  parameter int PW    = PW_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN   = LEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  product_accumulator_if.slave bus
);

  localparam int CNT_W = cnt_width(LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  acc_state_t       r_state;
  acc_state_t       w_next_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [ACC_W-1:0] r_sum;
  logic             r_sum_ovf;

  logic [PW-1:0]    w_product;
  logic [ACC_W-1:0] w_addend;
  logic [ACC_W-1:0] w_add_sum;
  logic             w_carry;
  logic             w_ovf_next;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_last;
  logic             w_take;

  assign w_product  = bus.in_product;
  assign w_addend   = ACC_W'(w_product);
  assign w_ovf_next = r_ovf | w_carry;
  assign w_last     = (r_cnt == LAST_CNT);

  // Acceptance is derived from the state register rather than w_in_ready so
  // there is no combinational loop through the next-state logic. A product
  // presented together with clr is dropped.
  assign w_accept = bus.in_valid && (r_state == ACCUM) && !clr;
  assign w_take   = bus.out_ready && (r_state == HOLD) && !clr;

  acc_sat_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .a     (r_acc),
    .b     (w_addend),
    .sum   (w_add_sum),
    .carry (w_carry)
  );

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal written here is given a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      ACCUM: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && w_last) begin
          w_next_state = HOLD;
        end
      end
      HOLD: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_next_state = ACCUM;
        end
      end
      default: w_next_state = ACCUM;
    endcase
    if (clr) begin
      w_next_state = ACCUM;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: running sum, term count, sticky overflow and the held result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_sum     <= '0;
      r_sum_ovf <= 1'b0;
    end else if (clr) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_sum     <= '0;
      r_sum_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_add_sum;
      r_ovf <= w_ovf_next;
      r_cnt <= r_cnt + CNT_W'(1);
      // The LEN-th sum goes straight into the output register so the result
      // is presented the cycle after the final accept.
      if (w_last) begin
        r_sum     <= w_add_sum;
        r_sum_ovf <= w_ovf_next;
      end
    end else if (w_take) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_sum     <= '0;
      r_sum_ovf <= 1'b0;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_sum      = r_sum;
  assign bus.out_overflow = r_sum_ovf;
  assign bus.term_cnt     = r_cnt;

endmodule

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
// Drives two accumulators (ACC_W=12 and ACC_W=9, LEN=4) from the same product
// stream and compares both against a sum-of-list reference model.
// Build option PRODUCT_ACC_SATURATE_EN switches the model to saturation too.
// -----------------------------------------------------------------------------
module tb_product_accumulator;

  localparam int PW  = 8;
  localparam int LEN = 4;
  localparam int W0  = 12;
  localparam int W1  = 9;
  localparam int CW  = $clog2(LEN + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          in_valid;
  logic [PW-1:0] in_product;
  logic          out_ready;

  int checks = 0;
  int errors = 0;
  int q[$];          // products accepted toward the current result
  int s0, s1;
  bit o0, o1;

  always #5 clk = ~clk;

  product_accumulator_if #(.PW(PW), .ACC_W(W0), .LEN(LEN)) bus0 ();
  product_accumulator_if #(.PW(PW), .ACC_W(W1), .LEN(LEN)) bus1 ();

  assign bus0.in_valid   = in_valid;
  assign bus0.in_product = in_product;
  assign bus0.out_ready  = out_ready;
  assign bus1.in_valid   = in_valid;
  assign bus1.in_product = in_product;
  assign bus1.out_ready  = out_ready;

  product_accumulator #(.PW(PW), .ACC_W(W0), .LEN(LEN)) u_dut0 (
    .clk (clk), .rst (rst), .clr (clr), .bus (bus0)
  );

  product_accumulator #(.PW(PW), .ACC_W(W1), .LEN(LEN)) u_dut1 (
    .clk (clk), .rst (rst), .clr (clr), .bus (bus1)
  );

  // Reference: add the products one by one as plain integers; any partial sum
  // beyond 2^width-1 sets the overflow flag and wraps (or clamps).
  function automatic void ref_sum(input int width, input int prods[$],
                                  output int sum, output bit ovf);
    int maxv;
    maxv = (1 << width) - 1;
    sum  = 0;
    ovf  = 1'b0;
    foreach (prods[i]) begin
      sum += prods[i];
      if (sum > maxv) begin
        ovf = 1'b1;
`ifdef PRODUCT_ACC_SATURATE_EN
        sum = maxv;
`else
        sum -= maxv + 1;
`endif
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one product after gap idle cycles and hold it until accepted.
  task automatic offer(input int p, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_product = PW'(p);
    in_valid   = 1'b1;
    n = 0;
    while (!bus0.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus0.in_ready) begin
      checks++;
      errors++;
      $display("FAIL offer_timeout: in_ready=%0b after %0d cycles, required 1", bus0.in_ready, n);
    end
    tick();
    q.push_back(p);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_product = '0; out_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if ({bus0.out_valid, bus0.in_ready, bus0.term_cnt, bus0.out_overflow, bus0.out_sum} !==
        {1'b0, 1'b1, CW'(0), 1'b0, W0'(0)}) begin
      errors++;
      $display("FAIL reset_state0: valid=%0b ready=%0b cnt=%0d ovf=%0b sum=%0d, required 0 1 0 0 0",
               bus0.out_valid, bus0.in_ready, bus0.term_cnt, bus0.out_overflow, bus0.out_sum);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({bus1.out_valid, bus1.in_ready, bus1.term_cnt, bus1.out_overflow, bus1.out_sum} !==
        {1'b0, 1'b1, CW'(0), 1'b0, W1'(0)}) begin
      errors++;
      $display("FAIL reset_state1: valid=%0b ready=%0b cnt=%0d ovf=%0b sum=%0d, required 0 1 0 0 0",
               bus1.out_valid, bus1.in_ready, bus1.term_cnt, bus1.out_overflow, bus1.out_sum);
    end
  endtask

  // 225 x4 back-to-back: 900 on the 12-bit unit, overflow on the 9-bit unit.
  task automatic test_back_to_back();
    q.delete();
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_product = PW'(225);
    for (int i = 0; i < LEN; i++) begin
      tick();
      q.push_back(225);
      checks++;
      if ({bus0.out_valid, bus0.term_cnt} !== {(i == LEN - 1), CW'(i + 1)}) begin
        errors++;
        $display("FAIL b2b_progress: valid=%0b cnt=%0d, required valid=%0b cnt=%0d",
                 bus0.out_valid, bus0.term_cnt, (i == LEN - 1), i + 1);
      end
    end
    in_valid = 1'b0;
    ref_sum(W0, q, s0, o0);
    ref_sum(W1, q, s1, o1);
    checks++;
    if ({bus0.out_overflow, bus0.out_sum} !== {o0, W0'(s0)}) begin
      errors++;
      $display("FAIL b2b_result0: ovf=%0b sum=%0d, required ovf=%0b sum=%0d",
               bus0.out_overflow, bus0.out_sum, o0, s0);
    end
    checks++;
    if ({bus1.out_valid, bus1.out_overflow, bus1.out_sum} !== {1'b1, o1, W1'(s1)}) begin
      errors++;
      $display("FAIL b2b_result1_overflow: valid=%0b ovf=%0b sum=%0d, required 1 %0b %0d",
               bus1.out_valid, bus1.out_overflow, bus1.out_sum, o1, s1);
    end
    tick();
    checks++;
    if ({bus0.out_valid, bus0.in_ready, bus0.term_cnt} !== {1'b0, 1'b1, CW'(0)}) begin
      errors++;
      $display("FAIL b2b_taken: valid=%0b ready=%0b cnt=%0d, required 0 1 0",
               bus0.out_valid, bus0.in_ready, bus0.term_cnt);
    end
    out_ready = 1'b0;
  endtask

  // Products 3,0,5,7 each preceded by two idle cycles; idle cycles never count.
  task automatic test_gaps();
    int prods[4] = '{3, 0, 5, 7};
    q.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b0;
      repeat (2) begin
        tick();
        checks++;
        if (bus0.term_cnt !== CW'(q.size())) begin
          errors++;
          $display("FAIL gaps_idle_cnt: cnt=%0d, required %0d", bus0.term_cnt, q.size());
        end
      end
      in_valid   = 1'b1;
      in_product = PW'(prods[i]);
      tick();
      q.push_back(prods[i]);
      in_valid = 1'b0;
      checks++;
      if (bus0.term_cnt !== CW'(q.size())) begin
        errors++;
        $display("FAIL gaps_accept_cnt: cnt=%0d, required %0d", bus0.term_cnt, q.size());
      end
    end
    ref_sum(W0, q, s0, o0);
    checks++;
    if ({bus0.out_valid, bus0.out_overflow, bus0.out_sum} !== {1'b1, o0, W0'(s0)}) begin
      errors++;
      $display("FAIL gaps_result: valid=%0b ovf=%0b sum=%0d, required 1 %0b %0d",
               bus0.out_valid, bus0.out_overflow, bus0.out_sum, o0, s0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Result held with out_ready=0 while product 9 waits at the input.
  task automatic test_hold_stall();
    q.delete();
    offer(10, 0); offer(20, 0); offer(30, 0); offer(40, 0);
    ref_sum(W0, q, s0, o0);
    in_valid   = 1'b1;
    in_product = PW'(9);
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({bus0.in_ready, bus0.out_valid, bus0.term_cnt, bus0.out_sum} !==
          {1'b0, 1'b1, CW'(LEN), W0'(s0)}) begin
        errors++;
        $display("FAIL stall_hold: ready=%0b valid=%0b cnt=%0d sum=%0d, required 0 1 %0d %0d",
                 bus0.in_ready, bus0.out_valid, bus0.term_cnt, bus0.out_sum, LEN, s0);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if ({bus0.out_valid, bus0.in_ready, bus0.term_cnt} !== {1'b0, 1'b1, CW'(0)}) begin
      errors++;
      $display("FAIL stall_release: valid=%0b ready=%0b cnt=%0d, required 0 1 0",
               bus0.out_valid, bus0.in_ready, bus0.term_cnt);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (bus0.term_cnt !== CW'(1)) begin
      errors++;
      $display("FAIL stall_late_accept: cnt=%0d, required 1", bus0.term_cnt);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    q.delete();
  endtask

  // Asynchronous reset between clock edges, then a clean result.
  task automatic test_async_reset();
    q.delete();
    offer(100, 0); offer(100, 0);
    checks++;
    if (bus0.term_cnt !== CW'(2)) begin
      errors++;
      $display("FAIL areset_pre_cnt: cnt=%0d, required 2", bus0.term_cnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus0.out_valid, bus0.in_ready, bus0.term_cnt, bus0.out_overflow, bus0.out_sum} !==
        {1'b0, 1'b1, CW'(0), 1'b0, W0'(0)}) begin
      errors++;
      $display("FAIL areset_immediate: valid=%0b ready=%0b cnt=%0d ovf=%0b sum=%0d, required 0 1 0 0 0",
               bus0.out_valid, bus0.in_ready, bus0.term_cnt, bus0.out_overflow, bus0.out_sum);
    end
    #9 rst = 1'b0;
    tick();
    q.delete();
    offer(1, 0); offer(1, 0); offer(1, 0); offer(1, 0);
    ref_sum(W1, q, s1, o1);
    checks++;
    if ({bus1.out_valid, bus1.out_overflow, bus1.out_sum} !== {1'b1, o1, W1'(s1)}) begin
      errors++;
      $display("FAIL areset_after: valid=%0b ovf=%0b sum=%0d, required 1 %0b %0d",
               bus1.out_valid, bus1.out_overflow, bus1.out_sum, o1, s1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_clr();
    q.delete();
    offer(50, 0); offer(50, 0); offer(50, 0);
    in_valid   = 1'b1;
    in_product = PW'(50);
    clr        = 1'b1;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({bus0.out_valid, bus0.in_ready, bus0.term_cnt} !== {1'b0, 1'b1, CW'(0)}) begin
      errors++;
      $display("FAIL clr_accum: valid=%0b ready=%0b cnt=%0d, required 0 1 0",
               bus0.out_valid, bus0.in_ready, bus0.term_cnt);
    end
    q.delete();
    offer(50, 0); offer(50, 0); offer(50, 0); offer(50, 0);
    out_ready = 1'b1;
    clr       = 1'b1;
    tick();
    clr       = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({bus0.out_valid, bus0.term_cnt} !== {1'b0, CW'(0)}) begin
      errors++;
      $display("FAIL clr_hold: valid=%0b cnt=%0d, required 0 0", bus0.out_valid, bus0.term_cnt);
    end
    q.delete();
    offer(1, 0); offer(2, 1); offer(3, 0); offer(4, 0);
    ref_sum(W0, q, s0, o0);
    checks++;
    if ({bus0.out_valid, bus0.out_overflow, bus0.out_sum} !== {1'b1, o0, W0'(s0)}) begin
      errors++;
      $display("FAIL clr_fresh_result: valid=%0b ovf=%0b sum=%0d, required 1 %0b %0d",
               bus0.out_valid, bus0.out_overflow, bus0.out_sum, o0, s0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int stall;
    for (int r = 0; r < 25; r++) begin
      q.delete();
      for (int k = 0; k < LEN; k++) begin
        offer(int'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
      end
      ref_sum(W0, q, s0, o0);
      ref_sum(W1, q, s1, o1);
      stall = int'($urandom_range(0, 3));
      for (int c = 0; c <= stall; c++) begin
        checks++;
        if ({bus0.out_valid, bus0.out_overflow, bus0.out_sum} !== {1'b1, o0, W0'(s0)}) begin
          errors++;
          $display("FAIL rand_result0 r=%0d: valid=%0b ovf=%0b sum=%0d, required 1 %0b %0d",
                   r, bus0.out_valid, bus0.out_overflow, bus0.out_sum, o0, s0);
        end
        checks++;
        if ({bus1.out_valid, bus1.out_overflow, bus1.out_sum} !== {1'b1, o1, W1'(s1)}) begin
          errors++;
          $display("FAIL rand_result1 r=%0d: valid=%0b ovf=%0b sum=%0d, required 1 %0b %0d",
                   r, bus1.out_valid, bus1.out_overflow, bus1.out_sum, o1, s1);
        end
        if (c < stall) tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if ({bus1.out_valid, bus1.term_cnt} !== {1'b0, CW'(0)}) begin
        errors++;
        $display("FAIL rand_taken r=%0d: valid=%0b cnt=%0d, required 0 0",
                 r, bus1.out_valid, bus1.term_cnt);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_hold_stall();
    test_async_reset();
    test_clr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
